clk_div_multi: RTL and testbench

Multi-channel programmable clock divider, the parametrised successor of the fixed single-divisor divider. Each of NUM_CH channels divides clk by a runtime divisor with runtime high-time (duty). Reloads are glitch-free: applied only at period boundaries. A global sync realigns phases and a per-channel tick marks each period start. Sits between the system clock and slow peripherals (display scan, debouncers, buzzer tones).

---
 rtl/clk_div_multi_if.sv | 16 +
 rtl/clk_div_multi.sv | 72 +++++++
 tb/tb_clk_div_multi.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and output bundle of the multi-channel clock divider
interface clk_div_multi_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 20
);
   logic [NUM_CH-1:0]       en;
   logic                    load;
   logic                    sync;
   logic [NUM_CH*CNT_W-1:0] div_in;
   logic [NUM_CH*CNT_W-1:0] high_in;
   logic [NUM_CH-1:0]       div_clk;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pend;
   modport master(output en, load, sync, div_in, high_in, input div_clk, tick, pend);
   modport slave(input en, load, sync, div_in, high_in, output div_clk, tick, pend);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock dividers with runtime divisor/high-time,
// reloads applied only at period boundaries, global phase sync and per-period tick.
module clk_div_multi #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 20,
   parameter int DEF_DIV  = 2,
   parameter int DEF_HIGH = 1
) (
   input logic            clk,
   input logic            rst,
   clk_div_multi_if.slave bus
);
   logic [CNT_W-1:0] cnt[NUM_CH];
   logic [CNT_W-1:0] act_div[NUM_CH];
   logic [CNT_W-1:0] act_high[NUM_CH];
   logic [CNT_W-1:0] sh_div[NUM_CH];
   logic [CNT_W-1:0] sh_high[NUM_CH];
   logic [CNT_W-1:0] top[NUM_CH];
   logic [CNT_W-1:0] cnt_nx[NUM_CH];
   logic [CNT_W-1:0] div_src[NUM_CH];
   logic [CNT_W-1:0] high_src[NUM_CH];
   logic [CNT_W-1:0] div_nx[NUM_CH];
   logic [CNT_W-1:0] high_nx[NUM_CH];
   logic [NUM_CH-1:0] run, rs, pend, div_clk, tick;

   // rs marks a period start: sync, first enabled edge, or wrap; it is also the reload point
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         div_src[i]  = bus.load ? bus.div_in[i*CNT_W +: CNT_W] : sh_div[i];
         high_src[i] = bus.load ? bus.high_in[i*CNT_W +: CNT_W] : sh_high[i];
         top[i]      = (act_div[i] < CNT_W'(2)) ? CNT_W'(1) : act_div[i] - CNT_W'(1);
         rs[i]       = bus.sync | ~run[i] | (cnt[i] == top[i]);
         cnt_nx[i]   = rs[i] ? '0 : cnt[i] + CNT_W'(1);
         div_nx[i]   = (rs[i] | ~bus.en[i]) ? div_src[i] : act_div[i];
         high_nx[i]  = (rs[i] | ~bus.en[i]) ? high_src[i] : act_high[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run     <= '0;
         pend    <= '0;
         div_clk <= '0;
         tick    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]      <= '0;
            act_div[i]  <= CNT_W'(DEF_DIV);
            act_high[i] <= CNT_W'(DEF_HIGH);
            sh_div[i]   <= CNT_W'(DEF_DIV);
            sh_high[i]  <= CNT_W'(DEF_HIGH);
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            run[i]      <= bus.en[i];
            act_div[i]  <= div_nx[i];
            act_high[i] <= high_nx[i];
            cnt[i]      <= bus.en[i] ? cnt_nx[i] : '0;
            tick[i]     <= bus.en[i] & rs[i];
            div_clk[i]  <= bus.en[i] & (cnt_nx[i] < high_nx[i]);
            pend[i]     <= bus.en[i] & ~rs[i] & (pend[i] | bus.load);
            if (bus.load) begin
               sh_div[i]  <= bus.div_in[i*CNT_W +: CNT_W];
               sh_high[i] <= bus.high_in[i*CNT_W +: CNT_W];
            end
         end
      end
   end

   assign bus.div_clk = div_clk;
   assign bus.tick    = tick;
   assign bus.pend    = pend;
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus against a timestamp-based reference model
module tb_clk_div_multi;
   localparam int NCH = 2;
   localparam int CW  = 8;

   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;

   clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus();
   clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(2), .DEF_HIGH(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // model: each channel remembers the cycle its current period began plus its active config
   int m_cyc;
   int m_start[NCH], m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
   bit m_on[NCH], m_pend[NCH];
   logic [NCH-1:0] e_clk, e_tick, e_pend;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff(input int d);
      return d < 2 ? 2 : d;
   endfunction

   function automatic int phase(input int k);
      return m_cyc - m_start[k];
   endfunction

   task automatic model_reset();
      m_cyc = 0;
      e_clk = '0; e_tick = '0; e_pend = '0;
      for (int k = 0; k < NCH; k++) begin
         m_start[k] = 0; m_on[k] = 0; m_pend[k] = 0;
         m_div[k] = 2; m_high[k] = 1; m_sdiv[k] = 2; m_shigh[k] = 1;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < NCH; k++) begin
         int din, hin;
         bit start;
         din = int'(bus.div_in[k*CW +: CW]);
         hin = int'(bus.high_in[k*CW +: CW]);
         if (!bus.en[k]) begin
            m_div[k]  = bus.load ? din : m_sdiv[k];
            m_high[k] = bus.load ? hin : m_shigh[k];
            m_on[k] = 0; m_pend[k] = 0;
            e_clk[k] = 0; e_tick[k] = 0; e_pend[k] = 0;
         end else begin
            start = bus.sync || !m_on[k] || phase(k) == eff(m_div[k]) - 1;
            if (start) begin
               m_div[k]  = bus.load ? din : m_sdiv[k];
               m_high[k] = bus.load ? hin : m_shigh[k];
               m_start[k] = m_cyc + 1;
               m_pend[k] = 0;
            end else if (bus.load) m_pend[k] = 1;
            m_on[k] = 1;
            e_tick[k] = start;
            e_pend[k] = m_pend[k];
            e_clk[k] = (m_cyc + 1 - m_start[k]) < m_high[k];
         end
         if (bus.load) begin
            m_sdiv[k] = din;
            m_shigh[k] = hin;
         end
      end
      m_cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("div_clk", int'(bus.div_clk), int'(e_clk));
      chk("tick", int'(bus.tick), int'(e_tick));
      chk("pend", int'(bus.pend), int'(e_pend));
      bus.load = 0;
      bus.sync = 0;
   endtask

   task automatic set_cfg(input int k, input int d, input int h);
      bus.div_in[k*CW +: CW] = CW'(d);
      bus.high_in[k*CW +: CW] = CW'(h);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // advance until the model says channel k sits on the last cycle of its period
   task automatic wait_last(input int k);
      int g = 0;
      while (!(m_on[k] && phase(k) == eff(m_div[k]) - 1) && g < 64) begin
         step();
         g++;
      end
      if (g >= 64) chk("wait_last_timeout", 0, 1);
   endtask

   initial begin
      bus.en = '0; bus.load = 0; bus.sync = 0; bus.div_in = '0; bus.high_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_div_clk", int'(bus.div_clk), 0);
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_pend", int'(bus.pend), 0);
      @(negedge clk);
      rst = 0;
      // defaults: period 2 on ch0, ch1 idle
      bus.en = 2'b01;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("dflt_tick", int'(bus.tick), (i % 2 == 0) ? 1 : 0);
         chk("dflt_clk", int'(bus.div_clk), (i % 2 == 0) ? 1 : 0);
      end
      // div 4 then load div 5 high 2 mid-period
      set_cfg(0, 4, 2); bus.load = 1;
      step();
      wait_last(0);
      step(); step();
      set_cfg(0, 5, 2); bus.load = 1;
      step();
      chk("mid_pend", int'(bus.pend[0]), 1);
      run(12);
      // degenerate divisors and high-times
      set_cfg(0, 0, 1); set_cfg(1, 1, 1); bus.en = 2'b11; bus.load = 1;
      run(10);
      set_cfg(0, 5, 0); set_cfg(1, 4, 7); bus.load = 1;
      run(12);
      chk("high7_const", int'(bus.div_clk[1]), 1);
      chk("high0_const", int'(bus.div_clk[0]), 0);
      // sync alignment of div 3 and div 6
      set_cfg(0, 3, 1); set_cfg(1, 6, 1); bus.load = 1;
      run(9);
      bus.sync = 1;
      step();
      chk("sync_tick", int'(bus.tick), 3);
      chk("sync_clk", int'(bus.div_clk), 3);
      step(); step();
      step();
      chk("sync3_tick", int'(bus.tick), 1);
      step(); step();
      step();
      chk("sync6_tick", int'(bus.tick), 3);
      // load coincident with wrap: div 4 -> 3
      set_cfg(0, 4, 2); bus.load = 1;
      step();
      wait_last(0);
      wait_last(0);
      set_cfg(0, 3, 1); bus.load = 1;
      step();
      chk("lt_pend", int'(bus.pend[0]), 0);
      chk("lt_tick", int'(bus.tick[0]), 1);
      step(); step();
      step();
      chk("lt_period3", int'(bus.tick[0]), 1);
      // drop and raise enable
      bus.en = 2'b10;
      step();
      chk("dis_clk", int'(bus.div_clk[0]), 0);
      run(3);
      bus.en = 2'b11;
      step();
      chk("reen_tick", int'(bus.tick[0]), 1);
      // random phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) begin
            for (int k = 0; k < NCH; k++) set_cfg(k, $urandom_range(9), $urandom_range(10));
            bus.load = 1;
         end
         if ($urandom_range(24) == 0) bus.sync = 1;
         for (int k = 0; k < NCH; k++)
            if ($urandom_range(39) == 0) bus.en[k] = ~bus.en[k];
         step();
      end
      // asynchronous reset in the high phase
      bus.en = 2'b00;
      set_cfg(0, 6, 3); set_cfg(1, 6, 3); bus.load = 1;
      step();
      step();
      bus.en = 2'b11;
      step();
      chk("pre_rst_clk", int'(bus.div_clk), 3);
      #2;
      rst = 1;
      #1;
      chk("arst_clk", int'(bus.div_clk), 0);
      chk("arst_tick", int'(bus.tick), 0);
      chk("arst_pend", int'(bus.pend), 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      bus.en = 2'b01;
      step();
      chk("post_rst_clk0", int'(bus.div_clk), 1);
      step();
      chk("post_rst_clk1", int'(bus.div_clk), 0);
      step();
      chk("post_rst_tick", int'(bus.tick), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
